// File: rtl/serv_rf_ram_arb.sv
// Arbiter sharing the 1R1W register-file SRAM between the SERV RF RAM interface and a host port.
// The RF always wins a port. A starvation guard holds back new core reads so the host makes progress.
module serv_rf_ram_arb #(
  parameter int width    = 32,
  parameter int csr_regs = 4,
  parameter int aw       = 5 + $clog2(32 + csr_regs) - $clog2(width),
  parameter int MAX_WAIT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_core_rreq,
  output logic             o_rf_rreq,
  input  logic [aw-1:0]    i_rf_waddr,
  input  logic [width-1:0] i_rf_wdata,
  input  logic             i_rf_wen,
  input  logic [aw-1:0]    i_rf_raddr,
  input  logic             i_rf_ren,
  output logic [width-1:0] o_rf_rdata,
  output logic [aw-1:0]    o_waddr,
  output logic [width-1:0] o_wdata,
  output logic             o_wen,
  output logic [aw-1:0]    o_raddr,
  output logic             o_ren,
  input  logic [width-1:0] i_rdata,
  input  logic             i_h_valid,
  input  logic             i_h_we,
  input  logic [aw-1:0]    i_h_addr,
  input  logic [width-1:0] i_h_wdata,
  output logic             o_h_ready,
  output logic             o_h_rvalid,
  output logic [width-1:0] o_h_rdata
);

  logic       h_wacc;
  logic       h_racc;
  logic       h_acc;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       hold;
  logic       pending;
  logic       rd_inflight;

  // Each SRAM port is granted independently: the host takes whichever port the RF leaves free.
  assign h_wacc    = i_h_valid &  i_h_we & ~i_rf_wen & ~i_rst;
  assign h_racc    = i_h_valid & ~i_h_we & ~i_rf_ren & ~i_rst;
  assign h_acc     = h_wacc | h_racc;
  assign o_h_ready = h_acc;

  assign o_wen      = i_rf_wen | h_wacc;
  assign o_waddr    = i_rf_wen ? i_rf_waddr : i_h_addr;
  assign o_wdata    = i_rf_wen ? i_rf_wdata : i_h_wdata;
  assign o_ren      = i_rf_ren | h_racc;
  assign o_raddr    = i_rf_ren ? i_rf_raddr : i_h_addr;
  assign o_rf_rdata = i_rdata;

  // A read deferred by hold is released on the first cycle hold is low.
  assign o_rf_rreq = ~hold & (i_core_rreq | pending);

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    wait_nxt = wait_cnt;
    if (!i_h_valid || h_acc)
      wait_nxt = '0;
    else if (wait_cnt != 8'(MAX_WAIT))
      wait_nxt = wait_cnt + 8'd1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt    <= '0;
      hold        <= 1'b0;
      pending     <= 1'b0;
      rd_inflight <= 1'b0;
      o_h_rvalid  <= 1'b0;
      o_h_rdata   <= '0;
    end else begin
      wait_cnt    <= wait_nxt;
      // Hold tracks the saturated counter; it drops with the counter on accept or withdrawal.
      hold        <= (wait_nxt == 8'(MAX_WAIT));
      pending     <= hold & (pending | i_core_rreq);
      rd_inflight <= h_racc;
      o_h_rvalid  <= rd_inflight;
      if (rd_inflight)
        o_h_rdata <= i_rdata;
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// Self-checking bench for serv_rf_ram_arb: directed scenarios followed by a randomized phase.
// Expected values come from a transaction-level model (reference memory, response queue, wait streak).
module tb_serv_rf_ram_arb;

  localparam int W        = 32;
  localparam int AW       = 6;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_rreq;
  logic          rf_rreq;
  logic [AW-1:0] rf_waddr, rf_raddr, h_addr;
  logic [W-1:0]  rf_wdata, h_wdata;
  logic          rf_wen, rf_ren, h_valid, h_we;
  logic [W-1:0]  rf_rdata, wdata, rdata, h_rdata;
  logic [AW-1:0] waddr, raddr;
  logic          wen, ren, h_ready, h_rvalid;

  always #5 clk = ~clk;

  serv_rf_ram_arb #(.width(W), .csr_regs(4), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_core_rreq(core_rreq), .o_rf_rreq(rf_rreq),
    .i_rf_waddr(rf_waddr), .i_rf_wdata(rf_wdata), .i_rf_wen(rf_wen),
    .i_rf_raddr(rf_raddr), .i_rf_ren(rf_ren), .o_rf_rdata(rf_rdata),
    .o_waddr(waddr), .o_wdata(wdata), .o_wen(wen),
    .o_raddr(raddr), .o_ren(ren), .i_rdata(rdata),
    .i_h_valid(h_valid), .i_h_we(h_we), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
    .o_h_ready(h_ready), .o_h_rvalid(h_rvalid), .o_h_rdata(h_rdata)
  );

  // SRAM macro: one write and one registered read per cycle, read-before-write.
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q;
  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;

  // Reference model state
  typedef struct {
    int           due;
    logic [W-1:0] data;
  } resp_t;

  logic [W-1:0] ref_mem [2**AW];
  resp_t        resp_q[$];
  logic [W-1:0] m_rdata;
  int           streak;
  bit           m_hold, m_pend, m_acc;
  int           cyc;
  int           checks, failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic         wacc, racc, exp_wen, exp_ren, exp_rv;
    logic [W-1:0] rd_val;
    wacc    = h_valid & h_we & ~rf_wen & ~rst;
    racc    = h_valid & ~h_we & ~rf_ren & ~rst;
    exp_wen = rf_wen | wacc;
    exp_ren = rf_ren | racc;
    @(negedge clk);
    check("h_ready", 32'(h_ready), 32'(wacc | racc));
    check("rf_rreq", 32'(rf_rreq), 32'(~m_hold & (core_rreq | m_pend)));
    check("wen", 32'(wen), 32'(exp_wen));
    if (exp_wen) begin
      check("waddr", 32'(waddr), 32'(rf_wen ? rf_waddr : h_addr));
      check("wdata", wdata, rf_wen ? rf_wdata : h_wdata);
    end
    check("ren", 32'(ren), 32'(exp_ren));
    if (exp_ren)
      check("raddr", 32'(raddr), 32'(rf_ren ? rf_raddr : h_addr));
    check("rf_rdata", rf_rdata, rdata);
    exp_rv = (resp_q.size() > 0) && (resp_q[0].due == cyc);
    if (exp_rv) begin
      m_rdata = resp_q[0].data;
      void'(resp_q.pop_front());
    end
    check("h_rvalid", 32'(h_rvalid), 32'(exp_rv));
    check("h_rdata", h_rdata, m_rdata);
    check("hold", 32'(dut.hold), 32'(m_hold));
    check("wait_cnt", 32'(dut.wait_cnt), 32'((streak > MAX_WAIT) ? MAX_WAIT : streak));
    @(posedge clk);
    rd_val = ref_mem[h_addr];
    if (rf_wen)    ref_mem[rf_waddr] = rf_wdata;
    else if (wacc) ref_mem[h_addr]   = h_wdata;
    m_acc = wacc | racc;
    if (rst) begin
      streak  = 0;
      m_hold  = 1'b0;
      m_pend  = 1'b0;
      m_rdata = '0;
      resp_q.delete();
    end else begin
      m_pend = m_hold & (m_pend | core_rreq);
      streak = (!h_valid || m_acc) ? 0 : streak + 1;
      m_hold = (streak >= MAX_WAIT);
      if (racc) resp_q.push_back('{due: cyc + 2, data: rd_val});
    end
    cyc++;
    #1;
  endtask

  task automatic host_req(input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
    h_valid = 1'b1;
    h_we    = we;
    h_addr  = a;
    h_wdata = d;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    streak = 0; m_hold = 1'b0; m_pend = 1'b0; m_acc = 1'b0; m_rdata = '0;
    rst = 1'b1; core_rreq = 1'b0;
    rf_wen = 1'b0; rf_ren = 1'b0; rf_waddr = '0; rf_raddr = '0; rf_wdata = '0;
    h_valid = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    @(posedge clk); #1;

    // Host request during reset must not be accepted
    host_req(1'b0, 6'd3, '0);
    cycle();
    rst = 1'b0; h_valid = 1'b0;
    cycle();

    // Preload the whole array through the RF write port
    for (int a = 0; a < 2**AW; a++) begin
      rf_wen = 1'b1; rf_waddr = AW'(a); rf_wdata = $urandom;
      cycle();
    end
    rf_wen = 1'b0;

    // Host write then read of address 5 with the RF idle
    host_req(1'b1, 6'd5, 32'hDEADBEEF); cycle();
    host_req(1'b0, 6'd5, '0);           cycle();
    h_valid = 1'b0; repeat (3) cycle();
    check("t1_readback", h_rdata, 32'hDEADBEEF);

    // Host read blocked for three RF read cycles
    rf_ren = 1'b1; rf_raddr = 6'd9;
    host_req(1'b0, 6'd7, '0);
    repeat (3) cycle();
    rf_ren = 1'b0; cycle();
    h_valid = 1'b0; repeat (2) cycle();

    // Host write proceeds alongside an RF read
    rf_ren = 1'b1; rf_raddr = 6'd12;
    host_req(1'b1, 6'd20, 32'hCAFE0001); cycle();
    h_valid = 1'b0; rf_ren = 1'b0; cycle();

    // Starvation: hold engages, core read is deferred and released after the host accept
    rf_ren = 1'b1; rf_raddr = 6'd2;
    host_req(1'b0, 6'd4, '0);
    repeat (5) cycle();
    check("t4_hold_set", 32'(dut.hold), 32'd1);
    core_rreq = 1'b1; cycle();
    core_rreq = 1'b0; cycle();
    rf_ren = 1'b0; cycle();
    h_valid = 1'b0; cycle();
    repeat (2) cycle();

    // Back-to-back host reads of preloaded 0x11/0x22/0x33
    rf_wen = 1'b1;
    rf_waddr = 6'd1; rf_wdata = 32'h11; cycle();
    rf_waddr = 6'd2; rf_wdata = 32'h22; cycle();
    rf_waddr = 6'd3; rf_wdata = 32'h33; cycle();
    rf_wen = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      host_req(1'b0, AW'(a), '0);
      cycle();
    end
    h_valid = 1'b0; repeat (2) cycle();
    check("t5_last_data", h_rdata, 32'h33);

    // Reset while hold is set with a deferred core read
    rf_ren = 1'b1;
    host_req(1'b0, 6'd9, '0);
    repeat (5) cycle();
    core_rreq = 1'b1; cycle();
    core_rreq = 1'b0; rst = 1'b1; cycle();
    rst = 1'b0; cycle();

    // Reset with a deferred core read and a host read in flight
    repeat (5) cycle();
    core_rreq = 1'b1; rf_ren = 1'b0; cycle();
    core_rreq = 1'b0; h_valid = 1'b0; rst = 1'b1; cycle();
    rst = 1'b0; repeat (3) cycle();

    // Randomized traffic honouring the host hold-stable rule
    for (int i = 0; i < 600; i++) begin
      if (i % 50 < 20) rf_ren = ($urandom_range(0, 7) != 0);
      else             rf_ren = ($urandom_range(0, 2) == 0);
      rf_raddr  = AW'($urandom);
      rf_wen    = ($urandom_range(0, 3) == 0);
      rf_waddr  = AW'($urandom);
      rf_wdata  = $urandom;
      core_rreq = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      if (h_valid && !m_acc) begin
        if ($urandom_range(0, 15) == 0) h_valid = 1'b0;
      end else begin
        h_valid = ($urandom_range(0, 2) != 0);
        h_we    = 1'($urandom_range(0, 1));
        h_addr  = AW'($urandom);
        h_wdata = $urandom;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serv_rf_ram_arb.md
Name: serv_rf_ram_arb

Overview:
- Shares the 1R1W register-file SRAM between the SERV RF RAM interface and a secondary host port (debug/loader access to GPRs and CSRs).
- Sits between the RF RAM interface's RAM-side outputs and the SRAM macro.
- The RF side always has priority and is never stalled mid-transaction.
- The host gets free port cycles. A starvation guard delays the core's next read request so the host always makes progress.

Parameters:
width, 32, SRAM data width (same value as the RF RAM interface).
csr_regs, 4, CSR registers allocated after the GPRs.
aw, 5+$clog2(32+csr_regs)-$clog2(width), SRAM address width (derived, do not override).
MAX_WAIT, 15, host-pending cycles before the starvation hold engages (1..255).

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_core_rreq  in  1  RF read request pulse from core
o_rf_rreq  out  1  read request forwarded to RF RAM interface
i_rf_waddr  in  aw  RF interface write address
i_rf_wdata  in  width  RF interface write data
i_rf_wen  in  1  RF interface write enable
i_rf_raddr  in  aw  RF interface read address
i_rf_ren  in  1  RF interface read enable
o_rf_rdata  out  width  read data to RF interface
o_waddr  out  aw  SRAM write address
o_wdata  out  width  SRAM write data
o_wen  out  1  SRAM write enable
o_raddr  out  aw  SRAM read address
o_ren  out  1  SRAM read enable
i_rdata  in  width  SRAM read data (1-cycle latency after o_ren)
i_h_valid  in  1  host request valid
i_h_we  in  1  host request is write
i_h_addr  in  aw  host address
i_h_wdata  in  width  host write data
o_h_ready  out  1  host request accepted this cycle
o_h_rvalid  out  1  host read data valid (1-cycle pulse)
o_h_rdata  out  width  host read data

Behaviour:
- Reset is synchronous and active-high on i_clk; a single clock domain.
- Reset values: o_h_rvalid=0, o_h_rdata=0, hold=0, wait counter=0, pending rreq=0, read pipeline valid bits=0. o_h_ready=0 while i_rst. o_rf_rreq=0 in the cycle after reset.
- Port grant is combinational, per SRAM port:
  - Host write accepted when i_h_valid & i_h_we & ~i_rf_wen.
  - Host read accepted when i_h_valid & ~i_h_we & ~i_rf_ren.
  - o_h_ready = (accepted) & ~i_rst.
  - A host write may proceed while the RF reads, and vice versa.
- SRAM muxing:
  - o_wen = i_rf_wen | host write accept; write address/data come from the RF when i_rf_wen, else from the host.
  - o_ren = i_rf_ren | host read accept; o_raddr likewise.
  - o_rf_rdata = i_rdata, passed through unconditionally. The RF samples only in the cycle after its own ren.
- Host read pipeline:
  - Accept at cycle N; SRAM data appears at N+1 and is registered into o_h_rdata at the end of N+1.
  - o_h_rvalid=1 during N+2 only. o_h_rdata holds until the next read response.
  - Back-to-back reads are allowed (one accept per cycle); responses stay in order with a fixed latency of 2.
  - Writes produce no response.
- Starvation guard (counter saturating at MAX_WAIT):
  - Increments each cycle i_h_valid & ~o_h_ready; clears on accept or when i_h_valid=0.
  - hold (registered) sets when the counter reaches MAX_WAIT.
  - hold clears on host accept, or when i_h_valid drops.
- Read request forwarding:
  - Normal case: o_rf_rreq = i_core_rreq & ~hold.
  - If i_core_rreq=1 while hold=1: latch pending; o_rf_rreq stays 0.
  - Once hold clears, pending is forwarded as a 1-cycle o_rf_rreq pulse in the next cycle, then pending clears.
  - If i_core_rreq arrives in the same cycle as the host accept that clears hold, it is latched and forwarded in the next cycle.
  - The core's ready (from the RF interface) simply arrives later; no extra handshake.
- Write requests are never delayed: the RF interface acknowledges writes immediately.
- Boundaries:
  - An in-flight RF transaction always completes. The host waits for a free port even under hold, which is bounded by one RF transaction.
  - Counter saturates and does not wrap.
  - Reset mid-hold drops the pending rreq and any in-flight host read response (o_h_rvalid stays 0).
  - Host signals must stay stable while i_h_valid & ~o_h_ready. Dropping i_h_valid early is tolerated: hold clears and pending is forwarded.

Test Plan:
- RF idle, host write addr 5 data 0xDEADBEEF then read addr 5 -> o_h_ready same cycle as each request; o_h_rvalid two cycles after read accept with o_h_rdata=0xDEADBEEF.
- Host read issued while i_rf_ren=1 for 3 cycles -> o_h_ready=0 for those 3 cycles, accepted on the first cycle ren=0; o_raddr=i_rf_raddr while RF reads.
- Host write while i_rf_ren=1, i_rf_wen=0 -> accepted immediately; o_wen=1 with the host address; RF read address unaffected.
- MAX_WAIT=4; RF reads continuously; host read pending; core pulses rreq after hold sets -> o_rf_rreq suppressed; host accepted when RF ren drops; o_rf_rreq pulse exactly one cycle after accept.
- Back-to-back host reads to addrs 1,2,3 with preloaded 0x11,0x22,0x33 -> o_h_rvalid on three consecutive cycles with data in order.
- Assert i_rst while hold=1 with a pending rreq and a host read in flight -> next cycle o_h_rvalid=0, o_rf_rreq=0, hold=0, counter=0.
